// File: rtl/player_controller.sv
// Player sprite controller: debounces the board buttons, moves the sprite once per frame
// and issues rate-limited fire pulses.
module player_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SPEED           = 2,
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 640,
    parameter int unsigned PLAYER_W        = 16,
    parameter int unsigned X_START         = 312,
    parameter int unsigned Y_POS           = 440,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       frame,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       fire,
    output logic [9:0] shot_x
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CoolW = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [CntW-1:0]   CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CoolW-1:0]  CoolInit = CoolW'(COOLDOWN_FRAMES);
    localparam logic signed [10:0] XLo     = 11'(X_MIN);
    localparam logic signed [10:0] XHi     = 11'(X_MAX - PLAYER_W);
    localparam logic signed [10:0] Step    = 11'(SPEED);

    localparam int BtnL = 0;
    localparam int BtnR = 1;
    localparam int BtnF = 2;

    typedef enum logic [1:0] {StIdle, StArmed, StCooldown} fire_state_e;

    logic [2:0]           btn_raw;
    logic [2:0]           sync1_q, sync2_q;
    logic [2:0]           level_q, level_d;
    logic [2:0][CntW-1:0] cnt_q, cnt_d;
    logic                 fire_prev_q;
    logic                 fire_edge;

    logic [9:0]           x_q, x_d;
    logic signed [10:0]   x_cur, x_left, x_right;

    fire_state_e          state_q, state_d;
    logic [CoolW-1:0]     cool_q, cool_d;
    logic                 fire_q, fire_d;
    logic [9:0]           shot_q, shot_d;

    assign btn_raw = {btn_fire, btn_right, btn_left};

    // Debounce: the counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    assign fire_edge = level_q[BtnF] & ~fire_prev_q;

    // Signed 11-bit math keeps the left move from wrapping below zero.
    always_comb begin
        x_cur   = signed'({1'b0, x_q});
        x_left  = x_cur - Step;
        x_right = x_cur + Step;
        x_d     = x_q;
        if (frame) begin
            case ({level_q[BtnL], level_q[BtnR]})
                2'b10:   x_d = (x_left < XLo) ? 10'(XLo) : x_left[9:0];
                2'b01:   x_d = (x_right > XHi) ? 10'(XHi) : x_right[9:0];
                default: x_d = x_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        fire_d  = 1'b0;
        shot_d  = shot_q;
        case (state_q)
            StIdle: begin
                if (fire_edge) state_d = StArmed;
            end
            StArmed: begin
                if (frame) begin
                    fire_d  = 1'b1;
                    shot_d  = x_q + 10'(PLAYER_W / 2);
                    cool_d  = CoolInit;
                    state_d = StCooldown;
                end
            end
            StCooldown: begin
                if (frame) begin
                    cool_d = cool_q - CoolW'(1);
                    if (cool_q == CoolW'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            fire_prev_q <= 1'b0;
            x_q         <= 10'(X_START);
            state_q     <= StIdle;
            cool_q      <= '0;
            fire_q      <= 1'b0;
            shot_q      <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            fire_prev_q <= level_q[BtnF];
            x_q         <= x_d;
            state_q     <= state_d;
            cool_q      <= cool_d;
            fire_q      <= fire_d;
            shot_q      <= shot_d;
        end
    end

    assign player_x = x_q;
    assign player_y = 10'(Y_POS);
    assign fire     = fire_q;
    assign shot_x   = shot_q;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: three instances (centre start, left-edge start, right-edge start)
// checked by a single monitor against queues of expected positions and shots.
module tb_player_controller;

    logic       clk;
    logic       arst;
    logic       btn_left, btn_right, btn_fire, frame;
    logic       lo_left, hi_right, tie_lo;
    logic [9:0] player_x, player_y, shot_x;
    logic       fire;
    logic [9:0] lo_x, lo_y, lo_shot_x, hi_x, hi_y, hi_shot_x;
    logic       lo_fire, hi_fire;

    typedef struct {
        int mx;
        int lx;
        int hx;
    } pos_t;

    pos_t pos_q[$];
    int   shot_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 0;
    bit   end_checked = 0;
    bit   mon_last_frame = 0;
    logic prev_fire = 1'b0;

    player_controller #(.DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(3)) dut (
        .clk(clk), .arst(arst), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire(btn_fire), .frame(frame), .player_x(player_x), .player_y(player_y),
        .fire(fire), .shot_x(shot_x)
    );

    player_controller #(.DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(3), .X_START(1)) dut_lo (
        .clk(clk), .arst(arst), .btn_left(lo_left), .btn_right(tie_lo),
        .btn_fire(tie_lo), .frame(frame), .player_x(lo_x), .player_y(lo_y),
        .fire(lo_fire), .shot_x(lo_shot_x)
    );

    player_controller #(.DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(3), .X_START(623)) dut_hi (
        .clk(clk), .arst(arst), .btn_left(tie_lo), .btn_right(hi_right),
        .btn_fire(tie_lo), .frame(frame), .player_x(hi_x), .player_y(hi_y),
        .fire(hi_fire), .shot_x(hi_shot_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sole owner of the check counters.
    initial begin
        pos_t p;
        forever begin
            @(negedge clk);
            if (!arst) begin
                check("rst_player_x", int'(player_x), 312);
                check("rst_player_y", int'(player_y), 440);
                check("rst_fire", int'(fire), 0);
                check("rst_shot_x", int'(shot_x), 0);
                check("rst_lo_x", int'(lo_x), 1);
                check("rst_hi_x", int'(hi_x), 623);
            end
            if (arst && mon_last_frame) begin
                if (pos_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pos_unexpected: frame update x=%0d with no expected entry",
                             player_x);
                end else begin
                    p = pos_q.pop_front();
                    check("player_x", int'(player_x), p.mx);
                    check("lo_clamp_x", int'(lo_x), p.lx);
                    check("hi_clamp_x", int'(hi_x), p.hx);
                    check("player_y", int'(player_y), 440);
                end
            end
            if (fire) begin
                check("fire_single_cycle", int'(prev_fire), 0);
                if (shot_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fire_unexpected: pulse with shot_x=%0d, expected no pulse",
                             shot_x);
                end else begin
                    check("shot_x", int'(shot_x), shot_q.pop_front());
                end
            end
            if (lo_fire || hi_fire) check("clamp_inst_fire", int'({lo_fire, hi_fire}), 0);
            prev_fire      = fire;
            mon_last_frame = frame;
            if (done && !end_checked) begin
                check("pos_queue_drained", pos_q.size(), 0);
                check("shot_queue_drained", shot_q.size(), 0);
                end_checked = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 20-cycle frame period; frame pulses in the last cycle.
    task automatic period(input int exp_x, input bit exp_shot, input int exp_shot_x,
                          input int fire_at, input bit glitch);
        pos_t p;
        for (int i = 0; i < 20; i++) begin
            frame = (i == 19);
            if (glitch) btn_right = (i % 3 == 0);
            if (i == fire_at) btn_fire = 1'b1;
            if (i == 1 && exp_shot) shot_q.push_back(exp_shot_x);
            if (i == 19) begin
                p.mx = exp_x;
                p.lx = 0;
                p.hx = 624;
                pos_q.push_back(p);
            end
            tick();
        end
        frame = 1'b0;
    endtask

    initial begin
        arst = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_fire = 1'b0;
        frame = 1'b0;
        tie_lo = 1'b0;
        lo_left = 1'b1;
        hi_right = 1'b1;
        repeat (3) tick();
        arst = 1'b1;

        // Glitchy right button must never be accepted.
        for (int f = 0; f < 5; f++) period(312, 0, 0, -1, 1);
        btn_right = 1'b0;

        // Fire, cooldown drop, re-fire after cooldown.
        period(312, 1, 320, 0, 0);
        btn_fire = 1'b0;
        period(312, 0, 0, -1, 0);
        period(312, 0, 0, 0, 0);
        btn_fire = 1'b0;
        period(312, 0, 0, -1, 0);
        period(312, 1, 320, 0, 0);
        btn_fire = 1'b0;
        period(312, 0, 0, -1, 0);
        period(312, 0, 0, -1, 0);
        period(312, 0, 0, -1, 0);
        // Press edge lands on the frame cycle: arm only, shoot next frame.
        period(312, 0, 0, 13, 0);
        btn_fire = 1'b0;
        period(312, 1, 320, -1, 0);
        for (int f = 0; f < 3; f++) period(312, 0, 0, -1, 0);

        // Hold right for 10 frames.
        btn_right = 1'b1;
        for (int f = 1; f <= 10; f++) period(312 + 2 * f, 0, 0, -1, 0);
        btn_right = 1'b0;
        period(332, 0, 0, -1, 0);

        // Both directions: hold.
        btn_left = 1'b1;
        btn_right = 1'b1;
        for (int f = 0; f < 5; f++) period(332, 0, 0, -1, 0);
        btn_left = 1'b0;
        btn_right = 1'b0;
        period(332, 0, 0, -1, 0);

        // Walk left to x=200.
        btn_left = 1'b1;
        for (int f = 1; f <= 66; f++) period(332 - 2 * f, 0, 0, -1, 0);
        btn_left = 1'b0;
        period(200, 0, 0, -1, 0);

        // Arm a shot, then reset asynchronously before any frame.
        btn_fire = 1'b1;
        repeat (10) tick();
        arst = 1'b0;
        btn_fire = 1'b0;
        repeat (3) tick();
        arst = 1'b1;
        period(312, 0, 0, -1, 0);
        period(312, 0, 0, -1, 0);

        done = 1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
